cpu_seq_ctrl: RTL and testbench
===============================

# cpu_seq_ctrl

Synchronous instruction sequencer for the 16 x 8-bit unified memory and the A/B accumulator pair of the small CPU. It fetches 8-bit instructions at the program counter, decodes the 4-bit opcode, and drives the single memory port for the fetch, load and store cycles. It retires each instruction with a done/ack handshake toward the next pipeline element, so the bench can single-step the same programs used against the asynchronous core.

## Interface
- `DATA_W`, default 8: memory word and instruction width.
- `ADDR_W`, default 4: memory address width. Must equal `DATA_W-4`.
- `RESET_PC`, default 0: PC value after reset.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  level; 1 permits fetching new instructions.
- `instr_ack_next`  in  1  next-stage acknowledge of `instr_done` (used only with the step feature).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd_en`  out  1  read strobe; `mem_rdata` is valid the following cycle.
- `mem_wr_en`  out  1  write strobe; write happens at this clock edge.
- `mem_wdata`  out  DATA_W  write data (always `reg_a`).
- `mem_rdata`  in  DATA_W  read data, 1-cycle latency.
- `pc`  out  ADDR_W  program counter.
- `ir`  out  DATA_W  instruction register.
- `reg_a`, `reg_b`  out  DATA_W  accumulators.
- `instr_done`  out  1  instruction retired.
- `halted`  out  1  HALT executed; sticky.
- `illegal`  out  1  undefined opcode seen; sticky.

## Operation
- Opcode is `ir[7:4]`; operand address is `ir[3:0]`.
  - `4'b1000` LOAD_A: `A <= MEM[addr]`.
  - `4'b1001` LOAD_B: `B <= MEM[addr]`.
  - `4'b0100` READ_A: `MEM[addr] <= A`.
  - `4'b0000` HALT.
  - Any other opcode executes as a NOP and sets `illegal`.
- FSM states and transitions:
  - IDLE: go to FETCH if `run=1`.
  - FETCH: drive `mem_rd_en=1`, `mem_addr=pc`.
  - DECODE: `ir <= mem_rdata`, `pc <= pc+1`.
  - EXEC: LOAD drives a read at addr. READ_A drives a write at addr. HALT goes to HALTED. NOP goes to RETIRE.
  - WB (LOAD only): capture `mem_rdata` into A or B.
  - RETIRE: go to FETCH if `run=1`, otherwise go to IDLE.
  - HALTED: terminal until reset.
- PC increments modulo 2^ADDR_W; 15 wraps to 0.
- `mem_rd_en` and `mem_wr_en` are never both 1. Outside FETCH/EXEC both are 0 and `mem_addr` holds its last value.
- `run` is sampled only in IDLE and RETIRE. Deasserting `run` mid-instruction lets that instruction complete.
- Reset values: `pc=RESET_PC`; `ir`, `reg_a`, `reg_b` and `mem_addr` are 0; all strobes, `instr_done`, `halted` and `illegal` are 0; state is IDLE. Asserting reset mid-instruction aborts it immediately, with no write issued after the reset edge.

## Timing
- Cycles from entering FETCH to RETIRE inclusive: LOAD 5, READ_A 4, NOP/illegal 4.
- `instr_done` is 1 exactly during RETIRE (single-cycle pulse when step mode is off).
- HALT path: FETCH → DECODE → EXEC → HALTED. `halted` rises on entry to HALTED and `instr_done` stays 0.
- `pc` has already advanced past the HALT instruction when `halted` rises.
- A LOAD issued immediately after a READ_A to the same address returns the new data, because the write commits before the next FETCH.

## Configuration
- `CPU_SEQ_STEP_EN` defined:
  - RETIRE holds `instr_done=1` until `instr_ack_next=1` is sampled.
  - It then goes to a WAIT_REL state (`instr_done=0`) until `instr_ack_next=0`.
  - Only then is `run` evaluated (4-phase handshake).
- Not defined: `instr_ack_next` is ignored and RETIRE lasts one cycle.

## Test plan
- Reset with `run=1` held, then release reset: first `mem_rd_en` occurs at `mem_addr=0` on the first cycle after IDLE. All outputs read 0 during reset.
- Program `MEM[0]=8'h8F`, `MEM[1]=8'h47`, `MEM[2]=8'h97`, `MEM[3]=8'h00`, `MEM[15]=8'hCC`, with `run=1`. Required result:
  - `reg_a=8'hCC`, `MEM[7]=8'hCC`, `reg_b=8'hCC`.
  - `halted=1`, `pc=4`.
  - 3 `instr_done` pulses; HALTED reached 17 cycles after the first FETCH.
- `MEM[0]=8'hF3` with `run=1`: `illegal=1`, A/B unchanged, PC advances. With all-NOP memory, PC wraps from 15 to 0 without stall.
- Deassert `run` during EXEC of a LOAD: the load completes, A is updated, the FSM rests in IDLE with `pc=1`, and there is no further `mem_rd_en`.
- Pulse `rst_n` low during EXEC of READ_A: no write after the reset edge, all outputs return to reset values, and execution restarts at PC 0.
- With `CPU_SEQ_STEP_EN` and `instr_ack_next` held at 0: `instr_done` stays 1 indefinitely. Raising ack drops `instr_done` on the next cycle. Lowering ack starts the next FETCH on the following cycle.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl - multi-cycle instruction sequencer for the small CPU.
//
// Fetches 8-bit instructions from a 16-entry unified memory through one
// synchronous port (1-cycle read latency), executes LOAD_A/LOAD_B/READ_A/HALT
// on the A/B accumulator pair and retires each instruction with instr_done.
// Undefined opcodes execute as NOPs and set the sticky illegal flag.
//
// Optional feature macro: CPU_SEQ_STEP_EN
//   defined   : instr_done is held until instr_ack_next is seen high, then a
//               release state waits for it to drop before run is sampled.
//   undefined : instr_ack_next is ignored; instr_done is a one-cycle pulse.
//
// Parameters: DATA_W (word width), ADDR_W (must equal DATA_W-4), RESET_PC.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   run                permits fetching new instructions (sampled at IDLE/RETIRE)
//   instr_ack_next     next-stage acknowledge of instr_done (step mode only)
//   mem_addr/rd_en/wr_en/wdata, mem_rdata   single memory port
//   pc, ir, reg_a, reg_b                   architectural state
//   instr_done, halted, illegal            status
module cpu_seq_ctrl #(
  parameter int          DATA_W   = 8,
  parameter int          ADDR_W   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              instr_ack_next,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_RETIRE,
    S_WAIT_REL,
    S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_HALT   = 4'b0000,
    OP_READ_A = 4'b0100,
    OP_LOAD_A = 4'b1000,
    OP_LOAD_B = 4'b1001
  } opcode_t;

  state_t            state;
  logic [3:0]        rd_op;
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] rd_addr;
  logic              run_sample;

  // Opcode/operand of the word arriving in DECODE; the memory strobes for
  // EXEC are registered outputs, so they are decided one cycle before ir is.
  assign rd_op     = mem_rdata[DATA_W-1 -: 4];
  assign rd_addr   = mem_rdata[ADDR_W-1:0];
  assign ir_op     = ir[DATA_W-1 -: 4];
  assign mem_wdata = reg_a;

  // States in which run decides between the next FETCH and IDLE.
  always_comb begin
    run_sample = 1'b0;
    case (state)
      S_IDLE:     run_sample = 1'b1;
`ifdef CPU_SEQ_STEP_EN
      S_WAIT_REL: run_sample = !instr_ack_next;
`else
      S_RETIRE:   run_sample = 1'b1;
`endif
      default:    run_sample = 1'b0;
    endcase
  end

`ifndef CPU_SEQ_STEP_EN
  logic unused_ack;
  assign unused_ack = instr_ack_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc         <= ADDR_W'(RESET_PC);
      ir         <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      instr_done <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      if (run_sample) begin
        instr_done <= 1'b0;
        if (run) begin
          state     <= S_FETCH;
          mem_rd_en <= 1'b1;
          mem_addr  <= pc;
        end else begin
          state <= S_IDLE;
        end
      end else begin
        case (state)
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            ir    <= mem_rdata;
            pc    <= pc + ADDR_W'(1);
            state <= S_EXEC;
            case (rd_op)
              OP_LOAD_A, OP_LOAD_B: begin
                mem_rd_en <= 1'b1;
                mem_addr  <= rd_addr;
              end
              OP_READ_A: begin
                mem_wr_en <= 1'b1;
                mem_addr  <= rd_addr;
              end
              default: ;
            endcase
          end
          S_EXEC: begin
            case (ir_op)
              OP_LOAD_A, OP_LOAD_B: state <= S_WB;
              OP_READ_A: begin
                state      <= S_RETIRE;
                instr_done <= 1'b1;
              end
              OP_HALT: begin
                state  <= S_HALTED;
                halted <= 1'b1;
              end
              default: begin
                illegal    <= 1'b1;
                state      <= S_RETIRE;
                instr_done <= 1'b1;
              end
            endcase
          end
          S_WB: begin
            if (ir_op == OP_LOAD_B) reg_b <= mem_rdata;
            else                    reg_a <= mem_rdata;
            state      <= S_RETIRE;
            instr_done <= 1'b1;
          end
`ifdef CPU_SEQ_STEP_EN
          S_RETIRE: begin
            if (instr_ack_next) begin
              instr_done <= 1'b0;
              state      <= S_WAIT_REL;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
`timescale 1ns/1ps
module tb_cpu_seq_ctrl;

`ifdef CPU_SEQ_STEP_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       ack_manual = 1'b0;
  logic       auto_ack = 1'b1;
  logic       load_mem = 1'b0;
  logic       instr_ack_next;
  logic [3:0] mem_addr;
  logic       mem_rd_en, mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [3:0] pc;
  logic [7:0] ir, reg_a, reg_b;
  logic       instr_done, halted, illegal;

  logic [7:0] mem  [16];
  logic [7:0] prog [16];
  int cyc = 0;

  int checks = 0, fails = 0;
  int done_cnt = 0, both_cnt = 0, last_done_cyc = 0, rel_cyc = 0;
  logic done_q = 1'b0;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] a, b;
    logic       ill;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0] instr, data;
    logic [3:0] addr;
    logic [7:0] a, b, mem_exp;
    logic       ill;
    int         len;
  } vec_t;
  vec_t vt[7];

  always #5 clk = ~clk;

  assign instr_ack_next = auto_ack ? instr_done : ack_manual;

  cpu_seq_ctrl #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_ack_next(instr_ack_next),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .pc(pc), .ir(ir),
    .reg_a(reg_a), .reg_b(reg_b), .instr_done(instr_done),
    .halted(halted), .illegal(illegal)
  );

  // Memory model: 1-cycle read latency, write at the strobe's clock edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_mem) mem <= prog;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_retire(input logic [3:0] p, input logic [7:0] a, input logic [7:0] b,
                               input logic ill);
    sb_t e;
    e.pc = p; e.a = a; e.b = b; e.ill = ill;
    sbq.push_back(e);
  endtask

  // One clock: sample on the falling edge and score any new retirement.
  task automatic tick();
    sb_t e;
    @(negedge clk);
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (instr_done && !done_q) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (sbq.size() == 0) begin
        checks++; fails++;
        $display("FAIL retire_unexpected: retire at pc=%0h, none expected", pc);
      end else begin
        e = sbq.pop_front();
        check("retire_pc", pc, e.pc);
        check("retire_a", reg_a, e.a);
        check("retire_b", reg_b, e.b);
        check("retire_illegal", illegal, e.ill);
      end
    end
    done_q = instr_done;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return mem_rd_en;
      1: return instr_done;
      2: return halted;
      default: return mem_wr_en;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int budget, input string name);
    int n = 0;
    while (!sig(w) && n < budget) begin
      tick();
      n++;
    end
    if (!sig(w)) begin
      checks++; fails++;
      $display("FAIL %s: timeout, signal not seen after %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {mem_addr, mem_rd_en, mem_wr_en, mem_wdata, pc, ir, reg_a, reg_b,
                 instr_done, halted, illegal}, 64'h0);
  endtask

  task automatic fill_prog(input logic [7:0] v);
    for (int k = 0; k < 16; k++) prog[k] = v;
  endtask

  // Reset, load prog into memory, verify reset state, release with run.
  task automatic start_prog(input logic do_run);
    rst_n = 1'b0; run = 1'b0; load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
    tick();
    check_reset_outputs("reset_outputs");
    sbq.delete();
    rst_n = 1'b1; run = do_run; rel_cyc = cyc;
  endtask

  task automatic first_fetch();
    wait_sig(0, 5, "first_fetch");
    check("first_fetch_cyc", cyc, rel_cyc + 1);
    check("first_fetch_addr", mem_addr, 4'd0);
  endtask

  initial begin
    int t0, base, n;

    // instr, data, addr, exp A, exp B, exp MEM[addr], illegal, FETCH..RETIRE
    vt[0] = '{8'h85, 8'h5A, 4'd5,  8'h5A, 8'h00, 8'h5A, 1'b0, 5};
    vt[1] = '{8'h9A, 8'h3C, 4'd10, 8'h00, 8'h3C, 8'h3C, 1'b0, 5};
    vt[2] = '{8'h4E, 8'h77, 4'd14, 8'h00, 8'h00, 8'h00, 1'b0, 4};
    vt[3] = '{8'hF3, 8'h11, 4'd3,  8'h00, 8'h00, 8'h11, 1'b1, 4};
    vt[4] = '{8'h2F, 8'h99, 4'd15, 8'h00, 8'h00, 8'h99, 1'b1, 4};
    vt[5] = '{8'h8F, 8'hA5, 4'd15, 8'hA5, 8'h00, 8'hA5, 1'b0, 5};
    vt[6] = '{8'h1C, 8'h42, 4'd12, 8'h00, 8'h00, 8'h42, 1'b1, 4};

    for (int i = 0; i < 7; i++) begin
      fill_prog(8'h00);
      prog[0] = vt[i].instr;
      prog[vt[i].addr] = vt[i].data;
      start_prog(1'b1);
      expect_retire(4'd1, vt[i].a, vt[i].b, vt[i].ill);
      first_fetch();
      t0 = cyc;
      wait_sig(1, 20, "vec_retire");
      check($sformatf("vec%0d_len", i), cyc - t0 + 1, vt[i].len);
      wait_sig(2, 20, "vec_halt");
      check($sformatf("vec%0d_halt_pc", i), pc, 4'd2);
      check($sformatf("vec%0d_mem", i), mem[vt[i].addr], vt[i].mem_exp);
      check($sformatf("vec%0d_done_low", i), instr_done, 1'b0);
    end

    // Reference program: LOAD_A 15, READ_A 7, LOAD_B 7, HALT.
    fill_prog(8'h00);
    prog[0] = 8'h8F; prog[1] = 8'h47; prog[2] = 8'h97; prog[3] = 8'h00; prog[15] = 8'hCC;
    start_prog(1'b1);
    expect_retire(4'd1, 8'hCC, 8'h00, 1'b0);
    expect_retire(4'd2, 8'hCC, 8'h00, 1'b0);
    expect_retire(4'd3, 8'hCC, 8'hCC, 1'b0);
    base = done_cnt;
    first_fetch();
    t0 = cyc;
    wait_sig(2, 40, "main_halt");
    check("main_halt_cycles", cyc - t0, 17 + 3 * EXTRA);
    repeat (4) tick();
    check("main_state", {reg_a, reg_b, mem[7], pc, halted, illegal, instr_done, mem_rd_en},
          {8'hCC, 8'hCC, 8'hCC, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0});
    check("main_done_count", done_cnt - base, 3);
    check("main_sb_empty", sbq.size(), 0);

    // All-illegal memory: PC wraps 15 -> 0 at full rate.
    fill_prog(8'h10);
    start_prog(1'b1);
    for (int k = 1; k <= 17; k++) expect_retire(4'(k % 16), 8'h00, 8'h00, 1'b1);
    base = done_cnt;
    first_fetch();
    t0 = cyc;
    n = 0;
    while (done_cnt - base < 17 && n < 200) begin tick(); n++; end
    run = 1'b0;
    check("wrap_retires", done_cnt - base, 17);
    check("wrap_timing", last_done_cyc - t0, (4 + EXTRA) * 17 - 1 - EXTRA);
    repeat (8) tick();
    check("wrap_rest", {pc, mem_rd_en, illegal}, {4'd1, 1'b0, 1'b1});

    // run dropped during EXEC of a LOAD: the load still completes.
    fill_prog(8'h00);
    prog[0] = 8'h85; prog[5] = 8'h5A;
    start_prog(1'b1);
    expect_retire(4'd1, 8'h5A, 8'h00, 1'b0);
    first_fetch();
    tick(); tick();
    check("exec_load_strobe", {mem_rd_en, mem_addr}, {1'b1, 4'd5});
    run = 1'b0;
    wait_sig(1, 10, "stop_retire");
    n = 0;
    repeat (6) begin tick(); if (mem_rd_en) n++; end
    check("stop_no_fetch", n, 0);
    check("stop_state", {reg_a, pc, halted, instr_done}, {8'h5A, 4'd1, 1'b0, 1'b0});

    // Reset pulse during EXEC of READ_A.
    fill_prog(8'h00);
    prog[0] = 8'h8F; prog[1] = 8'h47; prog[7] = 8'h11; prog[15] = 8'hCC;
    start_prog(1'b1);
    expect_retire(4'd1, 8'hCC, 8'h00, 1'b0);
    wait_sig(3, 20, "wr_strobe");
    check("wr_strobe_addr", {mem_addr, mem_wdata}, {4'd7, 8'hCC});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_outputs");
    tick(); tick();
    check("abort_no_write", mem[7], 8'h11);
    check("abort_sb_empty", sbq.size(), 0);
    rst_n = 1'b1; rel_cyc = cyc;
    expect_retire(4'd1, 8'hCC, 8'h00, 1'b0);
    expect_retire(4'd2, 8'hCC, 8'h00, 1'b0);
    first_fetch();
    wait_sig(2, 30, "restart_halt");
    check("restart_result", {mem[7], pc}, {8'hCC, 4'd3});

    // Retire handshake.
    fill_prog(8'h10);
    auto_ack = 1'b0; ack_manual = 1'b0;
    start_prog(1'b1);
    expect_retire(4'd1, 8'h00, 8'h00, 1'b1);
    expect_retire(4'd2, 8'h00, 8'h00, 1'b1);
    wait_sig(1, 20, "hs_retire");
`ifdef CPU_SEQ_STEP_EN
    n = 0;
    repeat (10) begin tick(); if (instr_done && !mem_rd_en) n++; end
    check("step_hold", n, 10);
    ack_manual = 1'b1;
    tick();
    check("step_drop", {instr_done, mem_rd_en}, 2'b00);
    tick();
    check("step_wait_rel", {instr_done, mem_rd_en}, 2'b00);
    ack_manual = 1'b0;
    tick();
    check("step_fetch", {mem_rd_en, mem_addr}, {1'b1, 4'd1});
    run = 1'b0; auto_ack = 1'b1;
`else
    tick();
    check("done_pulse", {instr_done, mem_rd_en, mem_addr}, {1'b0, 1'b1, 4'd1});
    run = 1'b0;
`endif
    wait_sig(1, 20, "hs_retire2");
    repeat (4) tick();
    check("hs_sb_empty", sbq.size(), 0);
    auto_ack = 1'b1;

    check("no_dual_strobe", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
